// File: rtl/c64_kbd_pkg.sv
// Shared definitions for the C64 keyboard matrix block:
// event record layout, special key codes and joystick bit positions.
package c64_kbd_pkg;

  localparam int KEY_W = 7;
  localparam int EV_W  = 9;

  localparam int EV_CLR = 8;
  localparam int EV_PRS = 7;

  localparam logic [KEY_W-1:0] KEY_RESTORE = 7'h40;

  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_FIRE  = 4;

  localparam logic [7:0] KEY_RETURN  = 8'h01;
  localparam logic [7:0] KEY_SPACE   = 8'h3C;
  localparam logic [7:0] KEY_RUNSTOP = 8'h3F;

  typedef struct packed {
    logic             clear;
    logic             pressed;
    logic [KEY_W-1:0] key;
  } kbd_ev_t;

  function automatic logic is_matrix_key(
    input logic [KEY_W-1:0] key
  );
    return !key[6];
  endfunction

  function automatic logic is_restore(
    input logic [KEY_W-1:0] key
  );
    return key == KEY_RESTORE;
  endfunction

endpackage

// File: rtl/c64_kbd_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Push is ignored when full, pop is ignored when empty.
module c64_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/c64_keyboard_matrix.sv
// C64 keyboard matrix: event FIFO, phi2-aligned key state,
// joystick merge and CIA port A/B level resolution.
module c64_keyboard_matrix
  import c64_kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi2_p,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [6:0] ev_key,
  input  logic       ev_pressed,
  input  logic       ev_clear,
  input  logic [7:0] pa_out,
  input  logic [7:0] pa_oe,
  input  logic [7:0] pb_out,
  input  logic [7:0] pb_oe,
  input  logic [4:0] joy1_n,
  input  logic [4:0] joy2_n,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic       restore_n,
  output logic       overflow
);

  kbd_ev_t   wr_ev;
  kbd_ev_t   rd_ev;
  logic      fifo_full;
  logic      fifo_empty;
  logic [AW:0] fifo_count;
  logic      pop;

  logic [7:0][7:0] mtx;

  logic [7:0] a_low;
  logic [7:0] b_low;
  logic [7:0] pa_hit;
  logic [7:0] pb_hit;
  logic [7:0] pa_nxt;
  logic [7:0] pb_nxt;

  assign wr_ev = '{
    clear:   ev_clear,
    pressed: ev_pressed,
    key:     ev_key
  };

  assign ev_ready = fifo_count != (AW+1)'(DEPTH);
  assign pop      = phi2_p & !fifo_empty;

  c64_kbd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EV_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_valid),
    .wdata (wr_ev),
    .pop   (pop),
    .rdata (rd_ev),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mtx       <= '0;
      restore_n <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      if (ev_valid && fifo_full)
        overflow <= 1'b1;
      if (pop) begin
        unique case (1'b1)
          rd_ev.clear: begin
            mtx       <= '0;
            restore_n <= 1'b1;
          end
          !rd_ev.clear && is_matrix_key(rd_ev.key):
            mtx[rd_ev.key[5:3]][rd_ev.key[2:0]] <= rd_ev.pressed;
          !rd_ev.clear && is_restore(rd_ev.key):
            restore_n <= !rd_ev.pressed;
          default: ;
        endcase
      end
    end
  end

  // One-level scan only: a pressed key shorts its column to its row.
  always_comb begin
    a_low  = pa_oe & ~pa_out;
    b_low  = pb_oe & ~pb_out;
    pa_hit = '0;
    pb_hit = '0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        pb_hit[r] = pb_hit[r] | (a_low[c] & mtx[c][r]);
        pa_hit[c] = pa_hit[c] | (b_low[r] & mtx[c][r]);
      end
    end
  end

  assign pa_nxt = (pa_out | ~pa_oe) & {3'b111, joy2_n} & ~pa_hit;
  assign pb_nxt = (pb_out | ~pb_oe) & {3'b111, joy1_n} & ~pb_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      pa_in <= 8'hFF;
      pb_in <= 8'hFF;
    end else begin
      pa_in <= pa_nxt;
      pb_in <= pb_nxt;
    end
  end

endmodule

// File: tb/tb_c64_keyboard_matrix.sv
// Self-checking bench for c64_keyboard_matrix against a
// behavioural key-state model and an event queue.
module tb_c64_keyboard_matrix;

  logic       clk = 1'b0;
  logic       reset;
  logic       phi2_p;
  logic       ev_valid;
  logic       ev_ready;
  logic [6:0] ev_key;
  logic       ev_pressed;
  logic       ev_clear;
  logic [7:0] pa_out;
  logic [7:0] pa_oe;
  logic [7:0] pb_out;
  logic [7:0] pb_oe;
  logic [4:0] joy1_n;
  logic [4:0] joy2_n;
  logic [7:0] pa_in;
  logic [7:0] pb_in;
  logic       restore_n;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  bit [63:0]  mdl;
  bit         mrest_n;
  bit         movf;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  c64_keyboard_matrix dut (
    .clk        (clk),
    .reset      (reset),
    .phi2_p     (phi2_p),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_key     (ev_key),
    .ev_pressed (ev_pressed),
    .ev_clear   (ev_clear),
    .pa_out     (pa_out),
    .pa_oe      (pa_oe),
    .pb_out     (pb_out),
    .pb_oe      (pb_oe),
    .joy1_n     (joy1_n),
    .joy2_n     (joy2_n),
    .pa_in      (pa_in),
    .pb_in      (pb_in),
    .restore_n  (restore_n),
    .overflow   (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void apply(input logic [8:0] e);
    if (e[8]) begin
      mdl     = '0;
      mrest_n = 1'b1;
    end else if (!e[6]) begin
      mdl[e[5:0]] = e[7];
    end else if (e[6:0] == 7'h40) begin
      mrest_n = !e[7];
    end
  endfunction

  task automatic step(input bit v, input logic [6:0] k,
                      input bit prs, input bit clr, input bit phi);
    bit acc;
    logic [8:0] e;
    ev_valid   = v;
    ev_key     = k;
    ev_pressed = prs;
    ev_clear   = clr;
    phi2_p     = phi;
    acc = v && (q.size() < 8);
    if (v && !acc) movf = 1'b1;
    if (phi && q.size() > 0) begin
      e = q.pop_front();
      apply(e);
    end
    if (acc) q.push_back({clr, prs, k});
    tick();
    ev_valid = 1'b0;
    phi2_p   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    mdl     = '0;
    mrest_n = 1'b1;
    movf    = 1'b0;
  endtask

  task automatic scan(output logic [63:0] m);
    pa_oe  = 8'hFF;
    pb_oe  = 8'h00;
    pb_out = 8'hFF;
    joy1_n = 5'h1F;
    joy2_n = 5'h1F;
    m = '0;
    for (int c = 0; c < 8; c++) begin
      pa_out = ~(8'd1 << c);
      tick();
      tick();
      m[c*8 +: 8] = ~pb_in;
    end
  endtask

  function automatic logic [7:0] exp_pb();
    logic [7:0] r;
    for (int rr = 0; rr < 8; rr++) begin
      bit hit = 0;
      bit hi  = pb_oe[rr] ? pb_out[rr] : 1'b1;
      bit jy  = (rr < 5) ? joy1_n[rr] : 1'b1;
      for (int cc = 0; cc < 8; cc++)
        if (pa_oe[cc] && !pa_out[cc] && mdl[cc*8+rr]) hit = 1;
      r[rr] = hi && jy && !hit;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_pa();
    logic [7:0] r;
    for (int cc = 0; cc < 8; cc++) begin
      bit hit = 0;
      bit hi  = pa_oe[cc] ? pa_out[cc] : 1'b1;
      bit jy  = (cc < 5) ? joy2_n[cc] : 1'b1;
      for (int rr = 0; rr < 8; rr++)
        if (pb_oe[rr] && !pb_out[rr] && mdl[cc*8+rr]) hit = 1;
      r[cc] = hi && jy && !hit;
    end
    return r;
  endfunction

  function automatic logic [6:0] rand_key(output bit clr);
    logic [6:0] k;
    clr = 0;
    case ($urandom_range(0, 9))
      0: begin clr = 1; k = 7'($urandom_range(0, 127)); end
      1: k = 7'h40;
      2: k = 7'($urandom_range(65, 127));
      default: k = 7'($urandom_range(0, 63));
    endcase
    return k;
  endfunction

  task automatic test_reset();
    pa_oe  = 8'hFF;
    pa_out = 8'h00;
    pb_oe  = 8'h00;
    pb_out = 8'hFF;
    joy1_n = 5'h1F;
    joy2_n = 5'h1F;
    reset  = 1'b1;
    tick();
    checks++;
    if (pa_in !== 8'hFF) begin
      failures++;
      $display("FAIL rst_pa got=%h exp=ff", pa_in);
    end
    checks++;
    if (pb_in !== 8'hFF) begin
      failures++;
      $display("FAIL rst_pb got=%h exp=ff", pb_in);
    end
    checks++;
    if (ev_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=1", ev_ready);
    end
    do_reset();
    tick();
    tick();
    checks++;
    if (pb_in !== 8'hFF) begin
      failures++;
      $display("FAIL idle_pb got=%h exp=ff", pb_in);
    end
    checks++;
    if (pa_in !== 8'h00) begin
      failures++;
      $display("FAIL idle_pa got=%h exp=00", pa_in);
    end
    checks++;
    if (restore_n !== 1'b1 || ev_ready !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL idle_flags got=%b%b%b exp=110",
               restore_n, ev_ready, overflow);
    end
  endtask

  task automatic test_single_key();
    step(1, 7'h0C, 1, 0, 0);
    step(0, 7'h00, 0, 0, 1);
    pa_oe  = 8'hFF;
    pa_out = 8'hFD;
    pb_oe  = 8'h00;
    pb_out = 8'hFF;
    tick();
    tick();
    checks++;
    if (pb_in !== 8'hEF) begin
      failures++;
      $display("FAIL key0c_col1 got=%h exp=ef", pb_in);
    end
    pa_out = 8'hFF;
    tick();
    tick();
    checks++;
    if (pb_in !== 8'hFF) begin
      failures++;
      $display("FAIL key0c_nocol got=%h exp=ff", pb_in);
    end
  endtask

  task automatic test_reverse();
    pa_oe  = 8'h00;
    pa_out = 8'hFF;
    pb_oe  = 8'hFF;
    pb_out = 8'hEF;
    tick();
    tick();
    checks++;
    if (pa_in !== 8'hFD) begin
      failures++;
      $display("FAIL rev_scan got=%h exp=fd", pa_in);
    end
    joy2_n = 5'b11110;
    tick();
    tick();
    checks++;
    if (pa_in !== 8'hFC) begin
      failures++;
      $display("FAIL rev_joy2 got=%h exp=fc", pa_in);
    end
    joy2_n = 5'h1F;
  endtask

  task automatic test_overflow();
    logic [63:0] m;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 7'($urandom_range(0, 63)), 1, 0, 0);
      if (i == 7) begin
        checks++;
        if (ev_ready !== 1'b0) begin
          failures++;
          $display("FAIL full_ready got=%b exp=0", ev_ready);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    for (int i = 0; i < 8; i++)
      step(0, 7'h00, 0, 0, 1);
    checks++;
    if (ev_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_ready got=%b exp=1", ev_ready);
    end
    scan(m);
    checks++;
    if (m !== mdl) begin
      failures++;
      $display("FAIL ovf_matrix got=%h exp=%h", m, mdl);
    end
  endtask

  task automatic test_restore_clear();
    logic [63:0] m;
    do_reset();
    step(1, 7'h40, 1, 0, 0);
    step(0, 7'h00, 0, 0, 1);
    checks++;
    if (restore_n !== 1'b0) begin
      failures++;
      $display("FAIL restore_press got=%b exp=0", restore_n);
    end
    step(1, 7'h01, 1, 0, 0);
    step(1, 7'h3C, 1, 0, 0);
    step(1, 7'h3F, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 7'h00, 0, 0, 1);
    scan(m);
    checks++;
    if (m !== 64'h9000_0000_0000_0002) begin
      failures++;
      $display("FAIL three_keys got=%h exp=9000000000000002", m);
    end
    step(1, 7'h15, 1, 1, 0);
    checks++;
    if (restore_n !== 1'b0) begin
      failures++;
      $display("FAIL clr_pending got=%b exp=0", restore_n);
    end
    step(0, 7'h00, 0, 0, 1);
    checks++;
    if (restore_n !== 1'b1) begin
      failures++;
      $display("FAIL clr_restore got=%b exp=1", restore_n);
    end
    scan(m);
    checks++;
    if (m !== 64'h0) begin
      failures++;
      $display("FAIL clr_matrix got=%h exp=0", m);
    end
  endtask

  task automatic test_reset_discard();
    logic [63:0] m;
    step(1, 7'h0C, 1, 0, 0);
    do_reset();
    step(0, 7'h00, 0, 0, 1);
    step(0, 7'h00, 0, 0, 1);
    scan(m);
    checks++;
    if (m !== 64'h0) begin
      failures++;
      $display("FAIL rst_discard got=%h exp=0", m);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m;
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1, 7'($urandom_range(0, 63)), 1'($urandom), 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, 7'($urandom_range(0, 63)), 1'($urandom), 0, 1);
    checks++;
    if (ev_ready !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_flags got=%b%b exp=10", ev_ready, overflow);
    end
    for (int i = 0; i < 4; i++)
      step(0, 7'h00, 0, 0, 1);
    scan(m);
    checks++;
    if (m !== mdl) begin
      failures++;
      $display("FAIL b2b_matrix got=%h exp=%h", m, mdl);
    end
  endtask

  task automatic test_random();
    bit clr;
    logic [6:0] k;
    logic [7:0] ea;
    logic [7:0] eb;
    for (int it = 0; it < 40; it++) begin
      for (int n = $urandom_range(0, 4); n > 0; n--) begin
        k = rand_key(clr);
        step(1, k, 1'($urandom), clr, 1'($urandom_range(0, 3) == 0));
      end
      for (int n = $urandom_range(0, 3); n > 0; n--)
        step(0, 7'h00, 0, 0, 1);
      pa_oe  = 8'($urandom);
      pa_out = 8'($urandom);
      pb_oe  = 8'($urandom);
      pb_out = 8'($urandom);
      joy1_n = 5'($urandom);
      joy2_n = 5'($urandom);
      tick();
      tick();
      ea = exp_pa();
      eb = exp_pb();
      checks++;
      if (pa_in !== ea || pb_in !== eb) begin
        failures++;
        $display("FAIL rnd_ports it=%0d got=%h/%h exp=%h/%h",
                 it, pa_in, pb_in, ea, eb);
      end
      checks++;
      if (restore_n !== mrest_n || overflow !== movf) begin
        failures++;
        $display("FAIL rnd_flags it=%0d got=%b%b exp=%b%b",
                 it, restore_n, overflow, mrest_n, movf);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    phi2_p     = 1'b0;
    ev_valid   = 1'b0;
    ev_key     = '0;
    ev_pressed = 1'b0;
    ev_clear   = 1'b0;
    pa_out     = 8'hFF;
    pa_oe      = 8'h00;
    pb_out     = 8'hFF;
    pb_oe      = 8'h00;
    joy1_n     = 5'h1F;
    joy2_n     = 5'h1F;
    test_reset();
    test_single_key();
    test_reverse();
    test_overflow();
    test_restore_clear();
    test_reset_discard();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
